reset_pulse_gen: RTL and testbench

RESET_PULSE_GEN -- requirements
Module: reset_pulse_gen

---
 rtl/reset_pulse_gen.sv | 124 ++++++++++++
 tb/tb_reset_pulse_gen.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reset_pulse_gen.sv
// Downstream reset pulse generator: drives an active-low reset line with
// power-on, sync, config and custom-length pulses, each followed by a guard gap.
module reset_pulse_gen #(
  parameter int SYNC_LEN   = 20,
  parameter int CONFIG_LEN = 40,
  parameter int GUARD_LEN  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_type,
  input  logic [7:0] cmd_len,
  output logic       cmd_ready,
  output logic       reset_n_out,
  output logic       busy,
  output logic       done,
  output logic       cmd_err
);

  typedef enum logic [1:0] {
    POR   = 2'd0,
    PULSE = 2'd1,
    GUARD = 2'd2,
    IDLE  = 2'd3
  } state_t;

  localparam logic [7:0] SyncLen   = 8'(SYNC_LEN);
  localparam logic [7:0] ConfigLen = 8'(CONFIG_LEN);
  localparam logic [7:0] GuardLen  = 8'(GUARD_LEN);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       reset_n_out_q, reset_n_out_d;
  logic [7:0] len_sel;
  logic       len_ok;
  logic       cnt_last;

  // Decode the requested pulse length; short custom lengths and the reserved type are refused.
  always_comb begin
    len_sel = 8'd0;
    len_ok  = 1'b0;
    case (cmd_type)
      2'b00: begin
        len_sel = SyncLen;
        len_ok  = 1'b1;
      end
      2'b01: begin
        len_sel = ConfigLen;
        len_ok  = 1'b1;
      end
      2'b10: begin
        len_sel = cmd_len;
        len_ok  = (cmd_len >= 8'd2);
      end
      default: begin
        len_sel = 8'd0;
        len_ok  = 1'b0;
      end
    endcase
  end

  // Terminal count is 1 so the counter never decrements through zero.
  assign cnt_last = (cnt_q <= 8'd1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cmd_ready = 1'b0;
    done      = 1'b0;
    cmd_err   = 1'b0;
    case (state_q)
      POR, PULSE: begin
        if (cnt_last) begin
          state_d = GUARD;
          cnt_d   = GuardLen;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      GUARD: begin
        if (cnt_last) begin
          done    = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (len_ok) begin
            state_d = PULSE;
            cnt_d   = len_sel;
          end else begin
            cmd_err = 1'b1;
          end
        end
      end
      default: begin
        state_d = POR;
        cnt_d   = ConfigLen;
      end
    endcase
  end

  // The output flop follows the next state so the line falls on the very edge that enters PULSE.
  assign reset_n_out_d = (state_d == GUARD) || (state_d == IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= POR;
      cnt_q         <= ConfigLen;
      reset_n_out_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      reset_n_out_q <= reset_n_out_d;
    end
  end

  assign reset_n_out = reset_n_out_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_reset_pulse_gen.sv
// Self-checking bench for reset_pulse_gen: a per-cycle reference model built
// from an expected-output schedule, plus table vectors and corner-case sequences.
module tb_reset_pulse_gen;

  localparam int SyncLen   = 20;
  localparam int ConfigLen = 40;
  localparam int GuardLen  = 8;

  logic       clk;
  logic       reset;
  logic       cmd_valid;
  logic [1:0] cmd_type;
  logic [7:0] cmd_len;
  logic       cmd_ready;
  logic       reset_n_out;
  logic       busy;
  logic       done;
  logic       cmd_err;

  int total = 0;
  int bad   = 0;

  reset_pulse_gen #(
    .SYNC_LEN  (SyncLen),
    .CONFIG_LEN(ConfigLen),
    .GUARD_LEN (GuardLen)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_type   (cmd_type),
    .cmd_len    (cmd_len),
    .cmd_ready  (cmd_ready),
    .reset_n_out(reset_n_out),
    .busy       (busy),
    .done       (done),
    .cmd_err    (cmd_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of the outputs still owed by the pulse in progress.
  typedef struct {
    logic rn;
    logic dn;
  } slot_t;

  slot_t schedQ[$];

  function automatic void pushPulse(input int n);
    slot_t s;
    for (int i = 0; i < n; i++) begin
      s.rn = 1'b0;
      s.dn = 1'b0;
      schedQ.push_back(s);
    end
    for (int i = 0; i < GuardLen; i++) begin
      s.rn = 1'b1;
      s.dn = (i == GuardLen - 1);
      schedQ.push_back(s);
    end
  endfunction

  function automatic int reqLen(input logic [1:0] t, input logic [7:0] l);
    case (t)
      2'b00:   return SyncLen;
      2'b01:   return ConfigLen;
      2'b10:   return (l >= 2) ? int'(l) : 0;
      default: return 0;
    endcase
  endfunction

  always @(negedge clk) begin
    int expRn, expBusy, expReady, expDone, expErr, n;
    slot_t s;
    if (reset) begin
      schedQ.delete();
      pushPulse(ConfigLen);
      expRn = 0; expBusy = 1; expReady = 0; expDone = 0; expErr = 0;
    end else if (schedQ.size() > 0) begin
      s = schedQ.pop_front();
      expRn = int'(s.rn); expBusy = 1; expReady = 0; expDone = int'(s.dn); expErr = 0;
    end else begin
      expRn = 1; expBusy = 0; expReady = 1; expDone = 0; expErr = 0;
      if (cmd_valid) begin
        n = reqLen(cmd_type, cmd_len);
        if (n > 0) pushPulse(n);
        else expErr = 1;
      end
    end
    check("model_reset_n_out", int'(reset_n_out), expRn);
    check("model_busy", int'(busy), expBusy);
    check("model_cmd_ready", int'(cmd_ready), expReady);
    check("model_done", int'(done), expDone);
    check("model_cmd_err", int'(cmd_err), expErr);
  end

  typedef struct {
    logic [1:0] cmdType;
    logic [7:0] cmdLen;
    int         expLow;
    logic       expErr;
  } vec_t;

  vec_t vecs[8];

  task automatic waitIdle();
    bit seen = 0;
    for (int i = 0; i < 600 && !seen; i++) begin
      @(negedge clk);
      if (cmd_ready) seen = 1;
    end
    check("wait_idle_timeout", int'(seen), 1);
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] t, input logic [7:0] l);
    cmd_valid = 1'b1;
    cmd_type  = t;
    cmd_len   = l;
  endtask

  task automatic checkOutput(input vec_t v);
    int lows = 0, busys = 0, dones = 0, window;
    @(negedge clk);
    check("vec_cmd_err", int'(cmd_err), int'(v.expErr));
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_type  = 2'($urandom);
    cmd_len   = 8'($urandom);
    window = (v.expLow > 0) ? v.expLow + GuardLen : 10;
    for (int i = 0; i < window; i++) begin
      @(negedge clk);
      if (!reset_n_out) lows++;
      if (busy) busys++;
      if (done) dones++;
    end
    check("vec_low_cycles", lows, v.expLow);
    check("vec_busy_cycles", busys, (v.expLow > 0) ? v.expLow + GuardLen : 0);
    check("vec_done_count", dones, (v.expLow > 0) ? 1 : 0);
  endtask

  task automatic powerOnCheck();
    int firstHigh = -1, doneAt = -1, readyAt = -1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (reset_n_out && firstHigh < 0) firstHigh = k;
      if (done && doneAt < 0) doneAt = k;
      if (cmd_ready && readyAt < 0) readyAt = k;
    end
    check("por_first_high_cycle", firstHigh, ConfigLen + 1);
    check("por_done_cycle", doneAt, ConfigLen + GuardLen);
    check("por_ready_cycle", readyAt, ConfigLen + GuardLen + 1);
  endtask

  initial begin
    int starts[$];
    logic prevRn;

    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_type  = 2'b00;
    cmd_len   = 8'd0;

    vecs[0] = '{2'b00, 8'd0,   SyncLen,   1'b0};
    vecs[1] = '{2'b01, 8'd3,   ConfigLen, 1'b0};
    vecs[2] = '{2'b10, 8'd5,   5,         1'b0};
    vecs[3] = '{2'b10, 8'd1,   0,         1'b1};
    vecs[4] = '{2'b10, 8'd0,   0,         1'b1};
    vecs[5] = '{2'b11, 8'd9,   0,         1'b1};
    vecs[6] = '{2'b10, 8'd2,   2,         1'b0};
    vecs[7] = '{2'b10, 8'd255, 255,       1'b0};

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    powerOnCheck();

    for (int i = 0; i < 8; i++) begin
      waitIdle();
      applyStimulus(vecs[i].cmdType, vecs[i].cmdLen);
      checkOutput(vecs[i]);
    end

    // Back-to-back config requests with valid held high.
    waitIdle();
    applyStimulus(2'b01, 8'd0);
    prevRn = 1'b1;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (prevRn && !reset_n_out) starts.push_back(i);
      prevRn = reset_n_out;
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    check("b2b_pulse_count", starts.size(), 4);
    for (int i = 1; i < starts.size(); i++)
      check("b2b_spacing", starts[i] - starts[i-1], ConfigLen + GuardLen + 1);

    // Reset 10 cycles into a config pulse, then a fresh power-on sequence.
    waitIdle();
    applyStimulus(2'b01, 8'd0);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("abort_pulse_low", int'(reset_n_out), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    powerOnCheck();

    // Reset during GUARD must pull the line low immediately.
    waitIdle();
    applyStimulus(2'b00, 8'd0);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (SyncLen + 2) @(posedge clk);
    #1;
    check("guard_line_high", int'(reset_n_out), 1);
    reset = 1'b1;
    #1;
    check("abort_guard_async_low", int'(reset_n_out), 0);
    check("abort_guard_busy", int'(busy), 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    powerOnCheck();

    // Randomized traffic checked cycle by cycle against the schedule model.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      reset     = ($urandom_range(0, 499) == 0);
      cmd_valid = ($urandom_range(0, 3) == 0);
      cmd_type  = 2'($urandom);
      cmd_len   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 2))
                                              : 8'($urandom_range(2, 30));
    end
    @(posedge clk);
    #1;
    reset     = 1'b0;
    cmd_valid = 1'b0;
    repeat (300) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
